covar_accum: RTL and testbench

//  Upstream stage of the uncertainty-propagation datapath. Consumes a stream of signed (x,y) sample pairs,

---
 rtl/covar_pkg.sv | 43 ++++
 rtl/covar_finalise.sv | 66 ++++++
 rtl/covar_accum.sv | 183 ++++++++++++++++++
 tb/tb_covar_accum.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/covar_pkg.sv
// Shared types and helpers for the covariance accumulator slice: sample/result
// widths, the accumulate/finalise FSM state encoding, and the 16-bit
// saturation functions used when scaling (co)variances and means.
package covar_pkg;

  localparam int SMP_W = 16;  // sample width (signed)
  localparam int RES_W = 16;  // result width

  typedef enum logic [2:0] {
    ST_ACC  = 3'd0,
    ST_FIN1 = 3'd1,
    ST_FIN2 = 3'd2,
    ST_FIN3 = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  // Clamp a signed value to the unsigned 16-bit range [0, 65535].
  function automatic logic [RES_W-1:0] sat_u16(input logic signed [63:0] v);
    logic [RES_W-1:0] res;
    if (v < 64'sd0) begin
      res = '0;
    end else if (v > 64'sd65535) begin
      res = 16'hFFFF;
    end else begin
      res = v[RES_W-1:0];
    end
    return res;
  endfunction

  // Clamp a signed value to the signed 16-bit range [-32768, 32767].
  function automatic logic [RES_W-1:0] sat_s16(input logic signed [63:0] v);
    logic [RES_W-1:0] res;
    if (v > 64'sd32767) begin
      res = 16'h7FFF;
    end else if (v < -64'sd32768) begin
      res = 16'h8000;
    end else begin
      res = v[RES_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/covar_finalise.sv
// Finalise datapath: one shared multiplier turns window sums into a scaled,
// saturated (co)variance; combinational, the step input picks the operands.
// Ports: i_step (FIN1=var_x, FIN2=var_y, FIN3=covar_xy), i_sx/i_sy (linear
//   sums), i_sxx/i_syy/i_sxy (quadratic sums), o_res (16-bit result bits).
module covar_finalise
  import covar_pkg::*;
#(
  parameter int LOG2N     = 4,
  parameter int VAR_SHIFT = 14
) (
  input  state_t                          i_step,
  input  logic signed [SMP_W+LOG2N-1:0]   i_sx,
  input  logic signed [SMP_W+LOG2N-1:0]   i_sy,
  input  logic signed [2*SMP_W+LOG2N-1:0] i_sxx,
  input  logic signed [2*SMP_W+LOG2N-1:0] i_syy,
  input  logic signed [2*SMP_W+LOG2N-1:0] i_sxy,
  output logic        [RES_W-1:0]         o_res
);

  localparam int SW = SMP_W + LOG2N;       // linear sum width
  localparam int QW = 2*SMP_W + LOG2N;     // quadratic sum width
  localparam int PW = 2*SW;                // Sp*Sq product width
  localparam int DW = PW + 1;              // exact N*Sqq - Sp*Sq width
  localparam int SH = 2*LOG2N + VAR_SHIFT; // /N^2 plus output scaling

  logic signed [SW-1:0] w_p;
  logic signed [SW-1:0] w_q;
  logic signed [QW-1:0] w_qq;
  logic signed [PW-1:0] w_prod;
  logic signed [DW-1:0] w_qq_sh;
  logic signed [DW-1:0] w_prod_x;
  logic signed [DW-1:0] w_d;
  logic signed [DW-1:0] w_r;
  logic signed [63:0]   w_r64;

  // Operand select; FIN1 operands double as the idle default.
  always_comb begin
    w_p  = i_sx;
    w_q  = i_sx;
    w_qq = i_sxx;
    case (i_step)
      ST_FIN2: begin
        w_p  = i_sy;
        w_q  = i_sy;
        w_qq = i_syy;
      end
      ST_FIN3: begin
        w_q  = i_sy;
        w_qq = i_sxy;
      end
      default: ;
    endcase
  end

  assign w_prod   = w_p * w_q;
  // N*Sqq as a left shift, sign-extended by one bit to the exact D width.
  assign w_qq_sh  = {w_qq[QW-1], w_qq, {LOG2N{1'b0}}};
  assign w_prod_x = {w_prod[PW-1], w_prod};
  assign w_d      = w_qq_sh - w_prod_x;
  // Arithmetic shift floors toward -inf, so small negative covariances become -1.
  assign w_r      = w_d >>> SH;
  assign w_r64    = {{(64-DW){w_r[DW-1]}}, w_r};

  assign o_res = (i_step == ST_FIN3) ? sat_s16(w_r64) : sat_u16(w_r64);

endmodule

// File: rtl/covar_accum.sv
// Window (co)variance accumulator: sums 2**LOG2N signed (x,y) pairs, then
// emits var_x, var_y, covar_xy as one valid/ready beat (result 4 cycles after
// the cycle the last pair is presented); in_ready drops while finalising and
// while the result beat is stalled. Optional macro COVAR_MEAN_OUT_EN adds
// mean_x/mean_y outputs.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_x/in_y sample
//   stream; win_clr restarts a partial window; out_valid/out_ready result
//   handshake; var_x, var_y (unsigned), covar_xy (signed) results.
module covar_accum
  import covar_pkg::*;
#(
  parameter int LOG2N     = 4,
  parameter int VAR_SHIFT = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [SMP_W-1:0] in_x,
  input  logic signed [SMP_W-1:0] in_y,
  input  logic                    win_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic        [RES_W-1:0] var_x,
  output logic        [RES_W-1:0] var_y,
  output logic signed [RES_W-1:0] covar_xy
`ifdef COVAR_MEAN_OUT_EN
  ,
  output logic signed [RES_W-1:0] mean_x,
  output logic signed [RES_W-1:0] mean_y
`endif
);

  localparam int SW = SMP_W + LOG2N;
  localparam int QW = 2*SMP_W + LOG2N;
  localparam logic [LOG2N-1:0] CNT_LAST = '1;  // N-1

  state_t r_state;
  state_t w_state_nxt;

  logic [LOG2N-1:0]     r_cnt;
  logic signed [SW-1:0] r_sx;
  logic signed [SW-1:0] r_sy;
  logic signed [QW-1:0] r_sxx;
  logic signed [QW-1:0] r_syy;
  logic signed [QW-1:0] r_sxy;

  logic [RES_W-1:0] r_var_x;
  logic [RES_W-1:0] r_var_y;
  logic [RES_W-1:0] r_covar;

  logic w_accept;
  logic signed [2*SMP_W-1:0] w_xx;
  logic signed [2*SMP_W-1:0] w_yy;
  logic signed [2*SMP_W-1:0] w_xy;
  logic [RES_W-1:0] w_fin_res;

  // Clear wins over a sample presented in the same cycle.
  assign w_accept = (r_state == ST_ACC) && in_valid && !win_clr;

  assign w_xx = in_x * in_x;
  assign w_yy = in_y * in_y;
  assign w_xy = in_x * in_y;

  covar_finalise #(
    .LOG2N     (LOG2N),
    .VAR_SHIFT (VAR_SHIFT)
  ) u_fin (
    .i_step (r_state),
    .i_sx   (r_sx),
    .i_sy   (r_sy),
    .i_sxx  (r_sxx),
    .i_syy  (r_syy),
    .i_sxy  (r_sxy),
    .o_res  (w_fin_res)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_ACC: begin
        in_ready = 1'b1;
        if (w_accept && (r_cnt == CNT_LAST)) begin
          w_state_nxt = ST_FIN1;
        end
      end
      ST_FIN1: w_state_nxt = ST_FIN2;
      ST_FIN2: w_state_nxt = ST_FIN3;
      ST_FIN3: w_state_nxt = ST_OUT;
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_ACC;
        end
      end
      default: w_state_nxt = ST_ACC;
    endcase
  end

  // Accumulators and counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sx  <= '0;
      r_sy  <= '0;
      r_sxx <= '0;
      r_syy <= '0;
      r_sxy <= '0;
    end else if (((r_state == ST_ACC) && win_clr) ||
                 ((r_state == ST_OUT) && out_ready)) begin
      r_cnt <= '0;
      r_sx  <= '0;
      r_sy  <= '0;
      r_sxx <= '0;
      r_syy <= '0;
      r_sxy <= '0;
    end else if (w_accept) begin
      // Counter wraps to 0 on the window's last pair.
      r_cnt <= r_cnt + 1'b1;
      r_sx  <= r_sx  + {{LOG2N{in_x[SMP_W-1]}}, in_x};
      r_sy  <= r_sy  + {{LOG2N{in_y[SMP_W-1]}}, in_y};
      r_sxx <= r_sxx + {{LOG2N{w_xx[2*SMP_W-1]}}, w_xx};
      r_syy <= r_syy + {{LOG2N{w_yy[2*SMP_W-1]}}, w_yy};
      r_sxy <= r_sxy + {{LOG2N{w_xy[2*SMP_W-1]}}, w_xy};
    end
  end

  // Result registers, one written per finalise step, held through OUT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_var_x <= '0;
      r_var_y <= '0;
      r_covar <= '0;
    end else begin
      case (r_state)
        ST_FIN1: r_var_x <= w_fin_res;
        ST_FIN2: r_var_y <= w_fin_res;
        ST_FIN3: r_covar <= w_fin_res;
        default: ;
      endcase
    end
  end

  assign var_x    = r_var_x;
  assign var_y    = r_var_y;
  assign covar_xy = r_covar;

`ifdef COVAR_MEAN_OUT_EN
  logic signed [RES_W-1:0] r_mean_x;
  logic signed [RES_W-1:0] r_mean_y;
  logic signed [63:0]      w_sx_ext;
  logic signed [63:0]      w_sy_ext;

  assign w_sx_ext = {{(64-SW){r_sx[SW-1]}}, r_sx};
  assign w_sy_ext = {{(64-SW){r_sy[SW-1]}}, r_sy};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mean_x <= '0;
      r_mean_y <= '0;
    end else if (r_state == ST_FIN1) begin
      r_mean_x <= sat_s16(w_sx_ext >>> LOG2N);
      r_mean_y <= sat_s16(w_sy_ext >>> LOG2N);
    end
  end

  assign mean_x = r_mean_x;
  assign mean_y = r_mean_y;
`endif

endmodule

// File: tb/tb_covar_accum.sv
// Directed bench for covar_accum with N=4: one instance at VAR_SHIFT=0 and a
// second at VAR_SHIFT=14 sharing the same stimulus. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_covar_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               in_valid;
  logic               win_clr;
  logic               out_ready;
  logic signed [15:0] in_x;
  logic signed [15:0] in_y;

  logic               in_ready,   out_valid;
  logic        [15:0] var_x,      var_y;
  logic signed [15:0] covar_xy;
  logic               in_ready14, out_valid14;
  logic        [15:0] var_x14,    var_y14;
  logic signed [15:0] covar_xy14;

  int n_err = 0;
  int n_chk = 0;

  logic signed [15:0] vx[4];
  logic signed [15:0] vy[4];

  covar_accum #(.LOG2N(2), .VAR_SHIFT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .win_clr(win_clr), .out_valid(out_valid),
    .out_ready(out_ready), .var_x(var_x), .var_y(var_y), .covar_xy(covar_xy)
  );

  covar_accum #(.LOG2N(2), .VAR_SHIFT(14)) u_dut14 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready14),
    .in_x(in_x), .in_y(in_y), .win_clr(win_clr), .out_valid(out_valid14),
    .out_ready(out_ready), .var_x(var_x14), .var_y(var_y14), .covar_xy(covar_xy14)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, expv);
    end
  endtask

  task automatic load(input int a0, input int a1, input int a2, input int a3,
                      input int b0, input int b1, input int b2, input int b3);
    vx[0] = 16'(a0); vx[1] = 16'(a1); vx[2] = 16'(a2); vx[3] = 16'(a3);
    vy[0] = 16'(b0); vy[1] = 16'(b1); vy[2] = 16'(b2); vy[3] = 16'(b3);
  endtask

  // Present n pairs back to back, one per cycle.
  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_x     = vx[i];
      in_y     = vy[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Called on the falling edge right after the last pair's accepting edge;
  // out_valid must first be seen 4 cycles after that pair was presented.
  task automatic wait_out(input string tag);
    int lat;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk(tag, 16'(lat), 16'd4);
  endtask

  task automatic check_res(input string tag, input logic [15:0] ex,
                           input logic [15:0] ey, input logic [15:0] ec);
    chk({tag, "_var_x"}, var_x, ex);
    chk({tag, "_var_y"}, var_y, ey);
    chk({tag, "_covar"}, covar_xy, ec);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    win_clr   = 1'b0;
    out_ready = 1'b1;
    in_x      = '0;
    in_y      = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    check_res("rst", 16'd0, 16'd0, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: basic window
    load(1, 2, 3, 4, 2, 4, 6, 8);
    send(4);
    chk("t1_fin_in_ready", 16'(in_ready), 16'd0);
    wait_out("t1_latency");
    check_res("t1", 16'd1, 16'd5, 16'd2);
    chk("t1_out_in_ready", 16'(in_ready), 16'd0);
    chk("t1_out14_valid", 16'(out_valid14), 16'd1);
    @(negedge clk);
    chk("t1_post_out_valid", 16'(out_valid), 16'd0);
    chk("t1_post_in_ready", 16'(in_ready), 16'd1);

    // Test 2: saturation, plus floor-toward-minus-infinity at VAR_SHIFT=14
    load(1000, -1000, 1000, -1000, -1000, 1000, -1000, 1000);
    send(4);
    wait_out("t2_latency");
    check_res("t2", 16'hFFFF, 16'hFFFF, 16'h8000);
    chk("t2_vs14_var_x", var_x14, 16'd61);
    chk("t2_vs14_var_y", var_y14, 16'd61);
    chk("t2_vs14_covar", covar_xy14, 16'hFFC2);
    @(negedge clk);

    // Test 3: constant input gives zero spread
    load(7, 7, 7, 7, 7, 7, 7, 7);
    send(4);
    wait_out("t3_latency");
    check_res("t3", 16'd0, 16'd0, 16'd0);
    chk("t3_vs14_var_x", var_x14, 16'd0);
    chk("t3_vs14_var_y", var_y14, 16'd0);
    chk("t3_vs14_covar", covar_xy14, 16'd0);
    @(negedge clk);

    // Test 4: output stall; samples offered during the stall must be refused
    out_ready = 1'b0;
    load(1, 2, 3, 4, 2, 4, 6, 8);
    send(4);
    wait_out("t4_latency");
    in_valid = 1'b1;
    in_x     = 16'sd100;
    in_y     = 16'sd100;
    repeat (10) @(negedge clk);
    chk("t4_stall_out_valid", 16'(out_valid), 16'd1);
    chk("t4_stall_in_ready", 16'(in_ready), 16'd0);
    check_res("t4_stall", 16'd1, 16'd5, 16'd2);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_post_out_valid", 16'(out_valid), 16'd0);
    chk("t4_post_in_ready", 16'(in_ready), 16'd1);
    send(4);
    wait_out("t4_next_latency");
    check_res("t4_next", 16'd1, 16'd5, 16'd2);
    @(negedge clk);

    // Test 5: win_clr discards partial window and its own-cycle sample
    load(1000, -1000, 1000, -1000, -1000, 1000, -1000, 1000);
    send(2);
    win_clr  = 1'b1;
    in_valid = 1'b1;
    in_x     = 16'sd5000;
    in_y     = -16'sd5000;
    @(negedge clk);
    win_clr  = 1'b0;
    in_valid = 1'b0;
    load(1, 2, 3, 4, 2, 4, 6, 8);
    send(4);
    wait_out("t5_latency");
    check_res("t5", 16'd1, 16'd5, 16'd2);
    @(negedge clk);

    // Test 6: reset mid-window
    load(1000, -1000, 1000, -1000, -1000, 1000, -1000, 1000);
    send(3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_rst_in_ready", 16'(in_ready), 16'd1);
    chk("t6_rst_out_valid", 16'(out_valid), 16'd0);
    check_res("t6_rst", 16'd0, 16'd0, 16'd0);
    load(1, 2, 3, 4, 2, 4, 6, 8);
    send(4);
    wait_out("t6_latency");
    check_res("t6", 16'd1, 16'd5, 16'd2);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
